// File: rtl/uart_word_sender_pkg.sv
// Shared definitions for the UART word sender: FSM encoding and constants.
package uart_word_sender_pkg;

  localparam int unsigned DEFAULT_NUM_CHARS = 5;
  localparam int unsigned STATE_W           = 3;
  localparam int unsigned HI_TIMEOUT        = 4;
  localparam int unsigned TO_W              = 2;

  localparam logic [7:0] CHAR_CR  = 8'h0D;
  localparam logic [7:0] CHAR_LF  = 8'h0A;
  localparam logic [7:0] CHAR_NUL = 8'h00;

  // Encodings are visible on o_state (LEDs/debug), so they are fixed.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_WAIT_READY = 3'd2,
    ST_STROBE     = 3'd3,
    ST_WAIT_HI    = 3'd4,
    ST_WAIT_LO    = 3'd5,
    ST_NEXT       = 3'd6,
    ST_DONE       = 3'd7
  } state_t;

endpackage

// File: rtl/uart_word_sender.sv
// Sends a fixed-width ASCII word (optionally followed by CR LF) one byte at a
// time through a start/busy byte transmitter such as async_transmitter.
module uart_word_sender
  import uart_word_sender_pkg::*;
#(
  parameter int unsigned NUM_CHARS   = DEFAULT_NUM_CHARS,
  parameter int unsigned APPEND_CRLF = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_start,
  input  logic [8*NUM_CHARS-1:0] i_word,
  input  logic                   i_busy,
  output logic                   o_tx_start,
  output logic [7:0]             o_tx_data,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [STATE_W-1:0]     o_state
);

  localparam int unsigned NUM_BYTES = NUM_CHARS + ((APPEND_CRLF != 0) ? 2 : 0);
  // Holds every position plus one past the last, so the index never wraps.
  localparam int unsigned IDX_W     = $clog2(NUM_CHARS + 3);

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [8*NUM_CHARS-1:0] shadow_q, shadow_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic [7:0]             sel_byte_c;

  // Indexed byte mux: shadow characters, then the optional CR and LF.
  always_comb begin
    sel_byte_c = CHAR_NUL;
    for (int unsigned i = 0; i < NUM_CHARS; i++) begin
      if (idx_q == IDX_W'(i)) sel_byte_c = shadow_q[8*i +: 8];
    end
    if (APPEND_CRLF != 0) begin
      if (idx_q == IDX_W'(NUM_CHARS))     sel_byte_c = CHAR_CR;
      if (idx_q == IDX_W'(NUM_CHARS + 1)) sel_byte_c = CHAR_LF;
    end
  end

  // Next-state logic; NUL bytes are skipped so short words can be padded.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    to_cnt_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          shadow_d = i_word;
          idx_d    = '0;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD:       state_d = (sel_byte_c == CHAR_NUL) ? ST_NEXT : ST_WAIT_READY;
      ST_WAIT_READY: if (!i_busy) state_d = ST_STROBE;
      ST_STROBE:     state_d = ST_WAIT_HI;
      ST_WAIT_HI: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (i_busy || (to_cnt_q == TO_W'(HI_TIMEOUT - 1))) state_d = ST_WAIT_LO;
      end
      ST_WAIT_LO:    if (!i_busy) state_d = ST_NEXT;
      ST_NEXT: begin
        idx_d   = idx_q + IDX_W'(1);
        state_d = (idx_q == IDX_W'(NUM_BYTES - 1)) ? ST_DONE : ST_LOAD;
      end
      ST_DONE:       state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // State register and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      shadow_q   <= '0;
      to_cnt_q   <= '0;
      o_tx_start <= 1'b0;
      o_tx_data  <= CHAR_NUL;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      to_cnt_q   <= to_cnt_d;
      o_tx_start <= (state_d == ST_STROBE);
      if (state_d == ST_STROBE) o_tx_data <= sel_byte_c;
      o_busy     <= (state_d != ST_IDLE) && (state_d != ST_DONE);
      o_done     <= (state_d == ST_DONE);
    end
  end

  assign o_state = state_q;

endmodule

// File: tb/tb_uart_word_sender.sv
// Scoreboard bench for uart_word_sender: two instances (with and without CR LF).
module tb_uart_word_sender;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start_a, start_b;
  logic [39:0] word_a, word_b;
  logic        busy_a, busy_b;
  logic        txs_a, txs_b;
  logic [7:0]  txd_a, txd_b;
  logic        ob_a, ob_b, od_a, od_b;
  logic [2:0]  st_a, st_b;

  int total = 0;
  int bad   = 0;

  int bcnt_a = 0, bcnt_b = 0;
  bit force_hi = 1'b0, never_busy = 1'b0;
  int strobes_a = 0, strobes_b = 0, dones_a = 0, dones_b = 0;
  int cyc = 0, last_strobe_a = 0, gap_a = 0;

  logic [8:0] qa[$];
  logic [8:0] qb[$];

  assign busy_a = force_hi | (!never_busy && (bcnt_a != 0));
  assign busy_b = (bcnt_b != 0);

  uart_word_sender #(.NUM_CHARS(5), .APPEND_CRLF(1)) u_dut_a (
    .clk(clk), .reset(reset), .i_start(start_a), .i_word(word_a), .i_busy(busy_a),
    .o_tx_start(txs_a), .o_tx_data(txd_a), .o_busy(ob_a), .o_done(od_a), .o_state(st_a)
  );

  uart_word_sender #(.NUM_CHARS(5), .APPEND_CRLF(0)) u_dut_b (
    .clk(clk), .reset(reset), .i_start(start_b), .i_word(word_b), .i_busy(busy_b),
    .o_tx_start(txs_b), .o_tx_data(txd_b), .o_busy(ob_b), .o_done(od_b), .o_state(st_b)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic pop_cmp(input int k, input logic [8:0] got);
    logic [8:0] e;
    if (k == 0) begin
      if (qa.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_event_a: got=%0h expected=none", got);
      end else begin
        e = qa.pop_front();
        check("event_a", 32'(got), 32'(e));
      end
    end else begin
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_event_b: got=%0h expected=none", got);
      end else begin
        e = qb.pop_front();
        check("event_b", 32'(got), 32'(e));
      end
    end
  endtask

  // Byte transmitter model: busy for 10 cycles after each strobe.
  initial forever begin
    @(posedge clk); #1;
    cyc++;
    if (txs_a) bcnt_a = 10; else if (bcnt_a > 0) bcnt_a--;
    if (txs_b) bcnt_b = 10; else if (bcnt_b > 0) bcnt_b--;
  end

  // Monitor: strobes carry {0,byte}, the done pulse carries 9'h100.
  initial forever begin
    @(negedge clk);
    if (txs_a) begin
      strobes_a++;
      gap_a = cyc - last_strobe_a;
      last_strobe_a = cyc;
      pop_cmp(0, {1'b0, txd_a});
    end
    if (od_a) begin
      dones_a++;
      pop_cmp(0, 9'h100);
      check("busy_low_at_done_a", 32'(ob_a), 32'd0);
    end
    if (txs_b) begin
      strobes_b++;
      pop_cmp(1, {1'b0, txd_b});
    end
    if (od_b) begin
      dones_b++;
      pop_cmp(1, 9'h100);
      check("busy_low_at_done_b", 32'(ob_b), 32'd0);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Push n bytes given first-byte-most-significant, optionally the done token.
  task automatic expect_seq(input int k, input int n, input logic [63:0] seq, input bit with_done);
    logic [7:0] b;
    for (int j = 0; j < n; j++) begin
      b = seq[8*(n-1-j) +: 8];
      if (k == 0) qa.push_back({1'b0, b}); else qb.push_back({1'b0, b});
    end
    if (with_done) begin
      if (k == 0) qa.push_back(9'h100); else qb.push_back(9'h100);
    end
  endtask

  task automatic send(input int k, input logic [39:0] w);
    if (k == 0) begin
      word_a = w; start_a = 1'b1; tick(); start_a = 1'b0;
      check("busy_after_accept_a", 32'(ob_a), 32'd1);
    end else begin
      word_b = w; start_b = 1'b1; tick(); start_b = 1'b0;
      check("busy_after_accept_b", 32'(ob_b), 32'd1);
    end
  endtask

  task automatic wait_done(input int k, input int budget);
    int  d0;
    bit  seen;
    d0   = (k == 0) ? dones_a : dones_b;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (((k == 0) ? dones_a : dones_b) != d0) begin seen = 1'b1; break; end
      tick();
    end
    check((k == 0) ? "done_seen_a" : "done_seen_b", 32'(seen), 32'd1);
  endtask

  initial begin
    int  s0;
    bit  found;

    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; word_a = '0; word_b = '0;
    tick(3);
    check("rst_tx_start", 32'(txs_a), 32'd0);
    check("rst_tx_data",  32'(txd_a), 32'h00);
    check("rst_busy",     32'(ob_a),  32'd0);
    check("rst_done",     32'(od_a),  32'd0);
    check("rst_state",    32'(st_a),  32'd0);
    reset = 1'b0;
    tick(2);

    // "HELLO" + CR LF
    expect_seq(0, 7, 64'h48_45_4C_4C_4F_0D_0A, 1'b1);
    send(0, 40'h4F_4C_4C_45_48);
    wait_done(0, 400);
    tick(3);

    // "WORLD" with i_word changed and i_start repeated mid-send
    expect_seq(0, 7, 64'h57_4F_52_4C_44_0D_0A, 1'b1);
    send(0, 40'h44_4C_52_4F_57);
    tick(15);
    word_a = 40'h58_58_58_58_58;
    start_a = 1'b1; tick(); start_a = 1'b0;
    tick(10);
    start_a = 1'b1; tick(2); start_a = 1'b0;
    wait_done(0, 400);
    s0 = strobes_a;
    tick(30);
    check("no_second_word", 32'(strobes_a - s0), 32'd0);
    check("idle_after_word", 32'(st_a), 32'd0);

    // Busy held high before the first strobe; NULs in "A\0B\0C" skipped
    force_hi = 1'b1;
    expect_seq(0, 5, 64'h41_42_43_0D_0A, 1'b1);
    s0 = strobes_a;
    send(0, 40'h43_00_42_00_41);
    tick(50);
    check("no_strobe_while_busy", 32'(strobes_a - s0), 32'd0);
    check("held_in_wait_ready", 32'(st_a), 32'd2);
    force_hi = 1'b0;
    @(negedge clk);
    check("strobe_not_same_cycle", 32'(txs_a), 32'd0);
    @(posedge clk); #1;
    check("strobe_one_cycle_later", 32'(txs_a), 32'd1);
    check("strobe_data_first", 32'(txd_a), 32'h41);
    wait_done(0, 400);
    tick(3);

    // Reset during WAIT_LO of byte index 3, then a fresh word from char 0
    expect_seq(0, 4, 64'h48_45_4C_4C, 1'b0);
    strobes_a = 0;
    send(0, 40'h4F_4C_4C_45_48);
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (st_a == 3'd5 && strobes_a == 4) begin found = 1'b1; break; end
      tick();
    end
    check("reached_wait_lo_byte3", 32'(found), 32'd1);
    reset = 1'b1;
    tick();
    check("midrst_tx_start", 32'(txs_a), 32'd0);
    check("midrst_tx_data",  32'(txd_a), 32'h00);
    check("midrst_busy",     32'(ob_a),  32'd0);
    check("midrst_done",     32'(od_a),  32'd0);
    check("midrst_state",    32'(st_a),  32'd0);
    reset = 1'b0;
    check("queue_drained_before_rst", 32'(qa.size()), 32'd0);
    tick(2);
    expect_seq(0, 7, 64'h48_45_4C_4C_4F_0D_0A, 1'b1);
    send(0, 40'h4F_4C_4C_45_48);
    wait_done(0, 400);
    tick(3);

    // Transmitter never goes busy: every byte leaves WAIT_HI by timeout
    never_busy = 1'b1;
    expect_seq(0, 7, 64'h48_45_4C_4C_4F_0D_0A, 1'b1);
    send(0, 40'h4F_4C_4C_45_48);
    wait_done(0, 400);
    check("timeout_strobe_gap", 32'(gap_a), 32'd9);
    never_busy = 1'b0;
    tick(3);

    // No CR LF: "HI" padded with NULs
    expect_seq(1, 2, 64'h48_49, 1'b1);
    send(1, 40'h00_00_00_49_48);
    wait_done(1, 400);
    tick(3);

    // No CR LF, all NUL: done with no strobes
    s0 = strobes_b;
    expect_seq(1, 0, 64'h0, 1'b1);
    send(1, 40'h0);
    wait_done(1, 100);
    check("all_nul_no_strobe", 32'(strobes_b - s0), 32'd0);

    tick(20);
    check("queue_a_empty", 32'(qa.size()), 32'd0);
    check("queue_b_empty", 32'(qb.size()), 32'd0);
    check("idle_b_end",    32'(st_b),      32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global safety net against a stuck simulation.
  initial begin
    #500000;
    $display("FAIL global_timeout: got=stuck expected=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_word_sender.md
UART_WORD_SENDER -- requirements
Module: uart_word_sender

Interface
REQ-001 Parameter NUM_CHARS, default 5, number of character slots in the word to send.
REQ-002 Parameter APPEND_CRLF, default 1; when 1, bytes 0x0D then 0x0A follow the word.
REQ-003 Port clk  in  1  single system clock; all logic is on its rising edge.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Port i_start  in  1  request to send the word currently on i_word.
REQ-006 Port i_word  in  8*NUM_CHARS  ASCII word; char 0 is in [7:0] and is sent first.
REQ-007 Port i_busy  in  1  busy flag from the downstream byte transmitter.
REQ-008 Port o_tx_start  out  1  one-cycle start strobe to the transmitter.
REQ-009 Port o_tx_data  out  8  byte to transmit; valid while o_tx_start is high.
REQ-010 Port o_busy  out  1  high from word acceptance until o_done.
REQ-011 Port o_done  out  1  one-cycle pulse when the final byte has left the transmitter.
REQ-012 Port o_state  out  3  current FSM state encoding, for LEDs and debug.

Function
REQ-013 States SHALL be IDLE, LOAD, WAIT_READY, STROBE, WAIT_HI, WAIT_LO, NEXT and DONE.
REQ-014 IDLE SHALL accept i_start=1 only; on acceptance it snapshots i_word into a shadow register, clears the byte index, and goes to LOAD.
REQ-015 i_start while o_busy=1 SHALL be ignored; i_word changes after acceptance SHALL NOT affect the bytes sent.
REQ-016 LOAD SHALL select the byte at the index: shadow chars 0..NUM_CHARS-1, then CR and LF if APPEND_CRLF=1.
REQ-017 A selected byte equal to 0x00 SHALL be skipped (LOAD to NEXT) with no strobe, so shorter words can be padded.
REQ-018 WAIT_READY SHALL hold until i_busy=0, then go to STROBE.
REQ-019 STROBE SHALL drive o_tx_start=1 for exactly one cycle, with o_tx_data equal to the selected byte, then go to WAIT_HI.
REQ-020 WAIT_HI SHALL wait for i_busy=1, then go to WAIT_LO.
REQ-021 WAIT_HI SHALL also advance to WAIT_LO after 4 cycles without i_busy=1, so the FSM does not hang.
REQ-022 WAIT_LO SHALL wait for i_busy=0, then go to NEXT.
REQ-023 NEXT SHALL increment the index; if the index was the last one, NEXT goes to DONE, otherwise to LOAD.
REQ-024 DONE SHALL pulse o_done=1 for one cycle, deassert o_busy on the same edge, and return to IDLE.
REQ-025 If every character is 0x00 and APPEND_CRLF=0, the FSM SHALL reach DONE with no strobes.
REQ-026 o_tx_data SHALL hold its last value outside STROBE; it is never X.
REQ-027 The index SHALL be wide enough for NUM_CHARS+2 positions and SHALL never wrap during a word.

Reset
REQ-028 reset=1 at any clock edge SHALL force: state IDLE, index 0, shadow 0, o_tx_start 0, o_tx_data 0x00, o_busy 0, o_done 0.
REQ-029 Reset during STROBE SHALL deassert o_tx_start on that edge.
REQ-030 A byte already inside the transmitter at reset is not tracked and finishes on its own.
REQ-031 reset has priority over i_start on the same edge.

Structure
REQ-032 Shared include uart_defs SHALL hold the state encodings, the CHAR_CR/CHAR_LF constants and the default NUM_CHARS.
REQ-033 No sub-module is required; byte selection SHALL be an indexed mux inside this module.
REQ-034 The block SHALL connect directly to async_transmitter: TxD_start, TxD_data, TxD_busy.

Verification
REQ-035 Test: i_word="HELLO" (48 45 4C 4C 4F), i_start pulse, busy model 10 cycles per byte -> exactly 7 strobes carrying 48 45 4C 4C 4F 0D 0A, then one o_done pulse.
REQ-036 Test: i_word="HI" plus three 0x00 chars, APPEND_CRLF=0 -> strobes 48 49 only; o_done follows.
REQ-037 Test: i_start repeated and i_word changed during a send -> the original byte sequence is unchanged and no second word is sent until after o_done.
REQ-038 Test: i_busy held high for 50 cycles before the first strobe -> o_tx_start stays 0 until i_busy falls, and the strobe comes 1 cycle later.
REQ-039 Test: reset asserted during WAIT_LO of byte 3 -> all outputs reach their reset values the next cycle; a new i_start sends from char 0.
REQ-040 Test: busy model never asserts -> each byte advances via the 4-cycle timeout; o_done is still reached.
